// File: rtl/ecc_decoder_pipe.sv
// ecc_decoder_pipe: two-stage SEC-DED decoder (8/4, 16/11, 32/26, raw) with valid/ready flow control and saturating error counters
module ecc_decoder_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int AMBA_WORD  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] codeword_y,
  input  logic [1:0]            cw_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [AMBA_WORD-1:0]  out_data,
  output logic [1:0]            err_num,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  single_cnt,
  output logic [CNT_WIDTH-1:0]  double_cnt
);
  typedef logic [5:0][31:0] rows_t;
  localparam rows_t H00 = {32'h0, 32'h0, 32'h0000_00FF, 32'h0000_00E4, 32'h0000_00D2, 32'h0000_00B1};
  localparam rows_t H01 = {32'h0, 32'h0000_FFFF, 32'h0000_FE08, 32'h0000_F1C4, 32'h0000_CDA2, 32'h0000_AB61};
  localparam rows_t H10 = {32'hFFFF_FFFF, 32'hFFFE_0010, 32'hFF01_FC08, 32'hF0F1_E384, 32'hCCCD_9B42, 32'hAAAB_56C1};

  function automatic rows_t rows(input logic [1:0] m);
    return m == 2'b00 ? H00 : m == 2'b01 ? H01 : H10;
  endfunction

  function automatic logic [5:0] syndrome(input rows_t h, input logic [31:0] c);
    logic [5:0] s;
    for (int i = 0; i < 6; i++) s[i] = ^(c & h[i]);
    return s;
  endfunction

  function automatic logic [5:0] column(input rows_t h, input int j);
    logic [5:0] c;
    for (int i = 0; i < 6; i++) c[i] = h[i][j];
    return c;
  endfunction

  logic                  s1_valid_q;
  logic [5:0]            s1_syn_q;
  logic [1:0]            s1_mode_q;
  logic [DATA_WIDTH-1:0] s1_cw_q;
  logic                  out_valid_q;
  logic [AMBA_WORD-1:0]  out_data_q, out_data_d;
  logic [1:0]            err_num_q, err_num_d;
  logic [CNT_WIDTH-1:0]  single_q, single_d, double_q, double_d;
  logic [31:0]           cw2, flip, corr, info;
  logic                  s2_en, msb, illegal, hs_out;
  rows_t                 h2;

  assign s2_en      = !out_valid_q || out_ready;
  assign in_ready   = rst && (!s1_valid_q || s2_en);
  assign hs_out     = out_valid_q && out_ready;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign err_num    = err_num_q;
  assign single_cnt = single_q;
  assign double_cnt = double_q;

  // stage 1: capture the word with its syndrome whenever the pipe can accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_syn_q   <= '0;
      s1_mode_q  <= '0;
      s1_cw_q    <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      s1_syn_q   <= syndrome(rows(cw_mode), 32'(codeword_y));
      s1_mode_q  <= cw_mode;
      s1_cw_q    <= codeword_y;
    end
  end

  // locate the single-bit error: the H column equal to the syndrome
  always_comb begin
    flip = '0;
    for (int j = 0; j < 32; j++) flip[j] = column(h2, j) == s1_syn_q;
  end

  // correction, extraction and error classification for the word in stage 1
  always_comb begin
    h2         = rows(s1_mode_q);
    cw2        = 32'(s1_cw_q);
    msb        = s1_mode_q == 2'b00 ? s1_syn_q[3] : s1_mode_q == 2'b01 ? s1_syn_q[4] : s1_syn_q[5];
    illegal    = s1_mode_q == 2'b10 ? DATA_WIDTH < 32 : s1_mode_q == 2'b01 ? DATA_WIDTH < 16 : 1'b0;
    corr       = cw2 ^ (msb ? flip : 32'h0);
    info       = s1_mode_q == 2'b00 ? {28'h0, corr[7:4]} :
                 s1_mode_q == 2'b01 ? {21'h0, corr[15:5]} :
                 s1_mode_q == 2'b10 ? {6'h0, corr[31:6]} : cw2;
    out_data_d = illegal ? '0 : AMBA_WORD'(info);
    err_num_d  = illegal ? 2'd3 :
                 (s1_mode_q == 2'b11 || s1_syn_q == '0) ? 2'd0 :
                 (msb && |flip) ? 2'd1 : 2'd2;
  end

  // stage 2: output register, frozen while the sink stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_num_q   <= '0;
    end else if (s2_en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
        err_num_q  <= err_num_d;
      end
    end
  end

  // saturating counters, clear has priority over a coincident increment
  always_comb begin
    single_d = cnt_clr ? '0 : (hs_out && err_num_q == 2'd1 && ~&single_q) ? single_q + CNT_WIDTH'(1) : single_q;
    double_d = cnt_clr ? '0 : (hs_out && err_num_q == 2'd2 && ~&double_q) ? double_q + CNT_WIDTH'(1) : double_q;
  end

  // counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      single_q <= '0;
      double_q <= '0;
    end else begin
      single_q <= single_d;
      double_q <= double_d;
    end
  end
endmodule

// File: doc/ecc_decoder_pipe.md
ECC_DECODER_PIPE -- requirements
Module: ecc_decoder_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32: codeword bus width; legal values 8, 16, 32.
REQ-002 Parameter AMBA_WORD, default 32: width of the out_data bus.
REQ-003 Parameter CNT_WIDTH, default 16: width of each error-statistics counter.
REQ-004 clk  in  1: single clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-low.
REQ-006 in_valid  in  1: input word valid.
REQ-007 in_ready  out  1: block accepts an input word; transfer occurs when in_valid && in_ready.
REQ-008 codeword_y  in  DATA_WIDTH: received codeword.
REQ-009 cw_mode  in  2: per-word codeword width (00 = 8/4, 01 = 16/11, 10 = 32/26, 11 = raw passthrough).
REQ-010 out_valid  out  1: output word valid.
REQ-011 out_ready  in  1: sink accepts; transfer occurs when out_valid && out_ready.
REQ-012 out_data  out  AMBA_WORD: corrected info bits, LSB-aligned and zero-extended.
REQ-013 err_num  out  2: 0 = none, 1 = corrected single, 2 = double/uncorrectable, 3 = illegal mode.
REQ-014 cnt_clr  in  1: synchronous clear of both counters.
REQ-015 single_cnt, double_cnt  out  CNT_WIDTH each: saturating error counters.

Function
REQ-016 Pipeline SHALL have two register stages: S1 holds the syndrome, mode and codeword; S2 is the output register, which holds out_data and err_num.
REQ-017 Latency from input handshake to out_valid SHALL be exactly 2 cycles when unstalled, at a throughput of 1 word/cycle.
REQ-018 in_ready SHALL equal !s1_valid || !out_valid || out_ready; S1 advances into S2 on the same condition.
REQ-019 While out_valid && !out_ready, out_data, err_num and out_valid SHALL hold stable.
REQ-020 Parity-check rows (MSB row = overall parity) SHALL be as follows.
- Mode 00: FF, E4, D2, B1.
- Mode 01: FFFF, FE08, F1C4, CDA2, AB61.
- Mode 10: FFFFFFFF, FFFE0010, FF01FC08, F0F1E384, CCCD9B42, AAAB56C1.
REQ-021 Syndrome bit i SHALL be the XOR-reduction of (codeword_y AND row i).
REQ-022 S == 0 SHALL give err_num = 0 and no correction.
REQ-023 S MSB = 1 with S equal to column j of H SHALL flip bit j and give err_num = 1.
REQ-024 S MSB = 1 with no column match, or S MSB = 0 with S != 0, SHALL give err_num = 2 and no correction.
REQ-025 out_data SHALL be corrected bits [7:4], [15:5] or [31:6] for modes 00, 01 and 10 respectively, zero-extended.
REQ-026 Mode 11 SHALL pass codeword_y through zero-extended, with err_num = 0.
REQ-027 A mode wider than DATA_WIDTH supports (01/10 when DATA_WIDTH = 8; 10 when DATA_WIDTH = 16) SHALL give out_data = 0 and err_num = 3.
REQ-028 On each output handshake, single_cnt SHALL increment when err_num = 1 and double_cnt SHALL increment when err_num = 2.
REQ-029 Each counter SHALL saturate at all-ones.
REQ-030 cnt_clr SHALL zero both counters next cycle; cnt_clr coincident with an increment SHALL result in 0.
REQ-031 cw_mode SHALL be sampled per word; a mode change between consecutive words SHALL need no bubble.

Reset
REQ-032 On rst low: s1_valid = 0, out_valid = 0, out_data = 0, err_num = 0, single_cnt = 0, double_cnt = 0, regardless of clk.
REQ-033 After rst deasserts, in_ready SHALL be 1 in the first cycle.
REQ-034 Words in flight at reset SHALL be discarded; no handshake SHALL occur while rst is low.

Verification
REQ-035 DATA_WIDTH = 32, mode 00, codeword 0x000000B1, out_ready = 1 -> 2 cycles later out_data = 0x0000000B, err_num = 0.
REQ-036 Mode 00, codeword 0xF1 -> out_data = 0xB, err_num = 1, single_cnt +1.
- Codeword 0xF0 -> out_data = 0xF, err_num = 2, double_cnt +1.
REQ-037 Back-to-back words with out_ready held low for 3 cycles:
- out_data stable throughout, in_ready = 0 after 2 words are captured.
- All words delivered in order, none lost or duplicated.
REQ-038 CNT_WIDTH = 4, 17 single-error words -> single_cnt = 15.
- cnt_clr coincident with an 18th single-error word -> single_cnt = 0.
REQ-039 DATA_WIDTH = 8, mode 01, any codeword -> out_data = 0, err_num = 3, counters unchanged.
REQ-040 rst asserted with 2 words in flight -> out_valid = 0 immediately.
- After release: no stale word emitted, counters = 0.
